mac_job_scheduler: RTL

//  Time-shares one MulAndAcc (5x5 sequential multiplier + 16-bit accumulator) between two requesters.
//  A requester wins a whole dot-product job of LEN operand pairs; the accumulator is not shareable mid-sum.
//  Per job: clears the MAC, streams the winner's pairs on the MAC's fetch handshake, counts completions, returns the 16-bit sum.

---
 rtl/mac_job_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: lends one sequential MulAndAcc to one of two
// requesters for a whole dot-product job and returns the 16-bit sum.
module mac_job_scheduler #(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               sch_clk_i,
  input  logic               sch_reset_i,
  input  logic [1:0]         req_i,
  input  logic [2*LEN_W-1:0] len_i,
  output logic [1:0]         gnt_o,
  input  logic [1:0]         op_valid_i,
  input  logic [9:0]         multiplicand_i,
  input  logic [9:0]         multiplier_i,
  output logic [1:0]         op_ready_o,
  output logic [1:0]         done_o,
  output logic [15:0]        result_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [4:0]         mac_multiplicand_o,
  output logic [4:0]         mac_multiplier_o,
  output logic               mac_nreset_o,
  input  logic               mac_fetching_input_i,
  input  logic               mac_updating_acc_result_i,
  input  logic [15:0]        mac_result_i
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, DONE
  } state_t;

  state_t state, state_n;

  logic             owner;
  logic             rr;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] completed;
  logic [1:0]       tag, tag_n;
  logic [1:0]       cnt, cnt_n;
  logic [WD_W-1:0]  wd;

  logic       win;
  logic       own_valid;
  logic [4:0] own_a;
  logic [4:0] own_b;
  logic       more;
  logic       offer;
  logic       xfer;
  logic       track;
  logic       push;
  logic       pop;
  logic       pop_real;
  logic       real_fly;
  logic       wd_run;
  logic       wd_hit;
  logic       last_done;

  assign win       = (req_i == 2'b11) ? ~rr : req_i[1];
  assign own_valid = owner ? op_valid_i[1] : op_valid_i[0];
  assign own_a     = owner ? multiplicand_i[9:5] : multiplicand_i[4:0];
  assign own_b     = owner ? multiplier_i[9:5] : multiplier_i[4:0];
  assign more      = issued < len;
  assign offer     = (state == FEED) & own_valid & more;
  assign xfer      = offer & mac_fetching_input_i;
  assign track     = (state == FEED) | (state == DRAIN);
  assign push      = track & mac_fetching_input_i;
  assign pop       = track & mac_updating_acc_result_i & (cnt != 2'd0);
  assign pop_real  = pop & tag[0];
  assign real_fly  = ((cnt != 2'd0) & tag[0]) | ((cnt == 2'd2) & tag[1]);
  assign wd_run    = track & real_fly & ~pop;
  assign wd_hit    = wd_run & (wd == WD_W'(TIMEOUT_CYC - 1));
  assign last_done = (state == DRAIN)
                   & ((completed + LEN_W'(pop_real)) == len);

  // In-flight tags: bit 0 is the oldest fetch, 1 = real pair, 0 = zero fill
  always_comb begin
    tag_n = tag;
    cnt_n = cnt;
    if (pop) begin
      tag_n = {1'b0, tag[1]};
      cnt_n = cnt - 2'd1;
    end
    if (push && cnt_n != 2'd2) begin
      tag_n[cnt_n[0]] = xfer;
      cnt_n = cnt_n + 2'd1;
    end
  end

  always_ff @(posedge sch_clk_i) begin
    if (sch_reset_i) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (req_i != 2'b00) state_n = CLEAR;
      CLEAR: state_n = (len == '0) ? DONE : FEED;
      FEED: begin
        if (wd_hit)
          state_n = IDLE;
        else if (xfer && (issued + LEN_W'(1)) == len)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (wd_hit)         state_n = IDLE;
        else if (last_done) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_o             = state != IDLE;
    mac_nreset_o       = ~(sch_reset_i | (state == CLEAR));
    op_ready_o         = owner ? {xfer, 1'b0} : {1'b0, xfer};
    mac_multiplicand_o = offer ? own_a : 5'd0;
    mac_multiplier_o   = offer ? own_b : 5'd0;
  end

  always_ff @(posedge sch_clk_i) begin
    if (sch_reset_i) begin
      gnt_o     <= 2'b00;
      done_o    <= 2'b00;
      result_o  <= 16'd0;
      timeout_o <= 1'b0;
      rr        <= 1'b1;
      owner     <= 1'b0;
      len       <= '0;
      issued    <= '0;
      completed <= '0;
      tag       <= 2'b00;
      cnt       <= 2'd0;
      wd        <= '0;
    end else begin
      done_o <= 2'b00;
      if (state == IDLE && req_i != 2'b00) begin
        owner <= win;
        rr    <= win;
        gnt_o <= win ? 2'b10 : 2'b01;
        len   <= win ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
      end
      if (state == CLEAR) begin
        issued    <= '0;
        completed <= '0;
        tag       <= 2'b00;
        cnt       <= 2'd0;
        wd        <= '0;
      end else begin
        if (xfer)     issued    <= issued + LEN_W'(1);
        if (pop_real) completed <= completed + LEN_W'(1);
        tag <= tag_n;
        cnt <= cnt_n;
        if (pop)         wd <= '0;
        else if (wd_run) wd <= wd + WD_W'(1);
      end
      if (state == DONE || wd_hit) begin
        done_o <= gnt_o;
        gnt_o  <= 2'b00;
      end
      if (state == DONE) result_o  <= mac_result_i;
      if (wd_hit)        timeout_o <= 1'b1;
    end
  end

endmodule
